// File: rtl/lms_ctr_pio_in.sv
// Avalon-MM input port: per-bit synchroniser, optional debounce, edge capture, IRQ mask, level IRQ.
// Optional debounce counters are compiled in when PIO_IN_DEBOUNCE_EN is defined.
module lms_ctr_pio_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_ECAP = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_dly_q;
  logic [WIDTH-1:0] rise, fall, edge_set;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d, cap_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         db_q, db_d;

  // A bit is accepted only after holding its new value for DEBOUNCE_CYCLES edges;
  // any return to the accepted value restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign db = s;
`endif

  assign rise = db & ~db_dly_q;
  assign fall = ~db & db_dly_q;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set = rise;
      1:       edge_set = fall;
      default: edge_set = rise | fall;
    endcase
  end

  // Zero-wait-state slave: a write (chipselect & ~write_n) commits on the edge it is presented.
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr_en && address == ADDR_MASK) mask_d  = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_ECAP) cap_clr = writedata[WIDTH-1:0];
    // A new edge outranks a simultaneous W1C of the same bit.
    cap_d = (cap_q & ~cap_clr) | edge_set;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = db;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_ECAP: readdata_d[WIDTH-1:0] = cap_q;
      ADDR_RAW:  readdata_d[WIDTH-1:0] = s;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_dly_q   <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      db_dly_q   <= db;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

  logic unused_writedata;
  assign unused_writedata = ^writedata;

endmodule
